// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_DEPTH  = 32;

    // Widest field portSlice can return, and the bus it reads (up to four ports).
    localparam int SLICE_W     = 32;
    localparam int SLICE_BUS_W = 4 * SLICE_W;

    function automatic logic [SLICE_W-1:0] portSlice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int                     p,
        input int                     w
    );
        logic [SLICE_BUS_W-1:0] sh;
        sh = bus >> (p * w);
        return sh[SLICE_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array select, zero-register force and optional write bypass.
module regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] mem,
    input  logic [ADDR_W-1:0]            raddr,
    input  logic                         fwdEn,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata
);

    always_comb begin
        rdata = mem[raddr];
        if (raddr == '0) begin
            rdata = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (fwdEn && (raddr == waddr)) begin
            rdata = wdata;
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    logic unusedByp;
    assign unusedByp = ^{fwdEn, waddr, wdata};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero entry and sequential clear engine.
// Compile with REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    state_t                      state;
    logic [ADDR_W-1:0]           cnt;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                        fwdEn;
    logic [SLICE_BUS_W-1:0]      raddrExt;

    // Flop array rather than RAM: reset must wipe every entry in one step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            mem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (we && (waddr != '0)) begin
                        mem[waddr] <= wdata;
                    end
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Forward only writes that will actually commit; held reset keeps all reads at zero.
    assign fwdEn    = rst && we && (state == IDLE) && (waddr != '0);
    assign raddrExt = SLICE_BUS_W'(raddr);

    for (genvar p = 0; p < NUM_RD; p++) begin : gPort
        regfile_rd_port #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) uPort (
            .mem  (mem),
            .raddr(ADDR_W'(portSlice(raddrExt, p, ADDR_W))),
            .fwdEn(fwdEn),
            .waddr(waddr),
            .wdata(wdata),
            .rdata(rdata[p*DATA_W +: DATA_W])
        );
    end

endmodule
